uart_rx_ctrl: RTL and testbench
===============================

Name: uart_rx_ctrl

Overview:
- Receive-side sequencer for the UART full-duplex core.
- Watches the serial RX line and detects and validates the start bit.
- Generates mid-bit sampling strobes that drive the 9-bit right-shift receive register (8 data bits, LSB first, then the parity bit). The register is fed on its SIn/ena inputs and cleared through its sync active-low reset.
- Checks parity and stop bit, then reports frame completion and errors to the host side.

Parameters:
- CLKS_PER_BIT, 5208: clk cycles per bit (50 MHz / 9600 baud). Must be ≥ 4.
- PARITY_ODD, 0: 0 = even parity expected; 1 = odd parity expected.

Ports:
- clk  in  1: system clock, rising edge.
- rst  in  1: asynchronous active-low reset.
- rx  in  1: raw serial line, idle high, asynchronous to clk.
- sin  out  1: sampled bit value, to the shift register SIn.
- shift_en  out  1: one-cycle shift strobe, to the shift register ena.
- reg_clr_n  out  1: active-low one-cycle clear, to the shift register rst.
- busy  out  1: high from start-bit detection until return to IDLE.
- rx_done  out  1: one-cycle pulse; the shift register holds {parity, data[7:0]}.
- parity_err  out  1: parity mismatch for the last frame; held.
- frame_err  out  1: stop bit sampled low for the last frame; held.

Behaviour:
- Input synchronisation:
  - rx passes through a 2-FF synchroniser (rx_s); all decisions use rx_s.
  - Falling-edge detect compares rx_s with its previous value.
- Reset values (async, rst low):
  - State = IDLE; counters = 0.
  - sin = 1, shift_en = 0, rx_done = 0, busy = 0, parity_err = 0, frame_err = 0.
  - reg_clr_n = 0; it goes to 1 on the first clk edge after rst deasserts.
  - Synchroniser FFs reset to 1.
- Baud counter: width $clog2(CLKS_PER_BIT); cleared on every state entry.
- IDLE:
  - On an rx_s falling edge -> START; busy = 1.
- START:
  - At count == CLKS_PER_BIT/2 - 1, sample rx_s.
  - If high (false start): -> IDLE, busy = 0, no other output changes.
  - If low: reg_clr_n = 0 for that one cycle; parity_err and frame_err clear; parity accumulator = PARITY_ODD; bit_idx = 0 -> DATA.
- DATA:
  - At count == CLKS_PER_BIT - 1 (mid-bit, since START ended at mid-start-bit):
    - sin = sample; shift_en = 1 for exactly one cycle.
    - Parity accumulator ^= sample; bit_idx++.
  - After the 9th strobe (bit_idx = 8: parity bit) -> STOP.
  - sin holds its last value between strobes.
- STOP:
  - At count == CLKS_PER_BIT - 1, sample rx_s.
  - frame_err = ~sample; parity_err = accumulator (nonzero means mismatch).
  - rx_done = 1 for one cycle; -> IDLE; busy = 0 in that same cycle.
- Stop bit low (break or frame error):
  - Return to IDLE anyway.
  - No new frame starts until rx_s has gone high and then low again (edge detect requirement).
- rx changes between sample points are ignored.
- Exactly 9 shift_en pulses occur per accepted frame; none occur for a false start.
- Reset mid-frame: immediate return to IDLE with all reset values; a partial frame never raises rx_done.
- Latency: rx_done occurs 2 (synchroniser) + 1 (edge detect) + CLKS_PER_BIT/2 + 10·CLKS_PER_BIT cycles after the rx falling edge, ±1 cycle.

Optional Feature:
- Macro: UART_RX_MAJORITY_EN.
- Defined:
  - Each sample point (start, data, parity, stop) uses a 2-of-3 majority of rx_s.
  - The three samples are taken at counts target-1, target and target+1; the decision is made at target+1.
  - All strobes are therefore delayed by one cycle.
  - A single-cycle glitch at a sample point must not change the sampled bit.
- Undefined: a single sample at the target count, as described above.

Decomposition:
- Package uart_pkg:
  - State enum (IDLE, START, DATA, STOP).
  - Localparams DATA_BITS = 8 and FRAME_SHIFTS = 9.
  - Function computing counter width from CLKS_PER_BIT.
- Sub-module uart_rx_sync: 2-FF synchroniser plus falling-edge detect, reset to 1.
- The FSM and counters stay in uart_rx_ctrl.

Test Plan:
All cases use CLKS_PER_BIT = 16 and PARITY_ODD = 0 unless stated; the DUT is wired to the shift register.
1. Frame 0xA5, parity 0, stop 1 -> 9 shift_en pulses; register = 9'h0A5 at rx_done; parity_err = 0; frame_err = 0; busy low after rx_done.
2. Frame 0xA5 with parity bit 1 -> rx_done pulses; parity_err = 1; frame_err = 0; register = 9'h1A5. Then send a clean 0x3C (parity 0) -> parity_err clears at start confirmation; register = 9'h03C.
3. Low pulse of 5 cycles on idle rx -> DUT returns to IDLE; zero shift_en pulses; no reg_clr_n pulse; no rx_done.
4. Frame 0x00 with stop bit 0, rx held low 40 cycles, then high -> frame_err = 1; rx_done pulses once; no second frame until a new falling edge.
5. Drop rst for 1 cycle mid-DATA (after 4 shifts) -> all outputs at reset values immediately; no rx_done; next full frame 0x5A is received correctly.
6. UART_RX_MAJORITY_EN defined: 1-cycle glitch at mid-bit of data bit 3 of 0xFF -> register = 9'h0FF; parity_err = 0.

Source files
------------

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg: shared types and constants for the UART receive path.
//   rx_state_e   - receive sequencer states
//   DATA_BITS    - data bits per frame
//   FRAME_SHIFTS - shift strobes per frame (data bits plus parity)
//   cnt_width()  - baud counter width for a given clocks-per-bit value
// ---------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } rx_state_e;

    localparam int unsigned DATA_BITS    = 8;
    localparam int unsigned FRAME_SHIFTS = DATA_BITS + 1;

    function automatic int unsigned cnt_width(input int unsigned clks);
        return (clks > 1) ? $clog2(clks) : 1;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// ---------------------------------------------------------------------------
// uart_rx_sync: two-flop synchroniser for the raw RX line plus falling-edge
// detect on the synchronised value. All flops reset to 1 (idle line).
//   clk_i    - system clock
//   rst_ni   - asynchronous active-low reset
//   rx_i     - raw serial line, asynchronous to clk_i
//   rx_s_o   - synchronised line value
//   rx_fall_o- high for one cycle when rx_s_o goes 1 -> 0
// ---------------------------------------------------------------------------
module uart_rx_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic rx_i,
    output logic rx_s_o,
    output logic rx_fall_o
);

    logic rx_meta_q;
    logic rx_s_q;
    logic rx_prev_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rx_i;
            rx_s_q    <= rx_meta_q;
            rx_prev_q <= rx_s_q;
        end
    end

    assign rx_s_o    = rx_s_q;
    assign rx_fall_o = rx_prev_q & ~rx_s_q;

endmodule

// File: rtl/uart_rx_ctrl.sv
// ---------------------------------------------------------------------------
// uart_rx_ctrl: receive-side sequencer. Detects and validates the start bit,
// emits mid-bit shift strobes for an external 9-bit right-shift register
// (8 data bits LSB first, then parity), checks parity and stop bit and
// reports frame completion.
//
// Optional build macro UART_RX_MAJORITY_EN: every sample point uses a 2-of-3
// majority over three consecutive rx_s values; all strobes move one cycle
// later.
//
// Ports:
//   clk_i        - system clock, rising edge
//   rst_ni       - asynchronous active-low reset
//   rx_i         - raw serial line, idle high
//   sin_o        - sampled bit value to the shift register SIn
//   shift_en_o   - one-cycle shift strobe to the shift register ena
//   reg_clr_n_o  - active-low one-cycle clear to the shift register
//   busy_o       - high from start detection until back in idle
//   rx_done_o    - one-cycle pulse, shift register holds {parity, data}
//   parity_err_o - parity mismatch on the last frame (held)
//   frame_err_o  - stop bit sampled low on the last frame (held)
// ---------------------------------------------------------------------------
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 5208,
    parameter bit          PARITY_ODD   = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic rx_i,
    output logic sin_o,
    output logic shift_en_o,
    output logic reg_clr_n_o,
    output logic busy_o,
    output logic rx_done_o,
    output logic parity_err_o,
    output logic frame_err_o
);

    localparam int unsigned CntW = cnt_width(CLKS_PER_BIT);

    // Majority mode decides one cycle later so the three votes straddle the
    // original sample point; the counter never has to exceed CLKS_PER_BIT-1.
`ifdef UART_RX_MAJORITY_EN
    localparam logic [CntW-1:0] StartPt = CntW'(CLKS_PER_BIT / 2);
`else
    localparam logic [CntW-1:0] StartPt = CntW'(CLKS_PER_BIT / 2 - 1);
`endif
    localparam logic [CntW-1:0] BitPt   = CntW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]      LastIdx = 4'(FRAME_SHIFTS - 1);

    logic rx_s;
    logic rx_fall;
    logic sample;

    uart_rx_sync u_sync (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .rx_i      (rx_i),
        .rx_s_o    (rx_s),
        .rx_fall_o (rx_fall)
    );

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] hist_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hist_q <= 2'b11;
        end else begin
            hist_q <= {hist_q[0], rx_s};
        end
    end

    assign sample = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_s) | (hist_q[0] & rx_s);
`else
    assign sample = rx_s;
`endif

    rx_state_e       state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [3:0]      idx_q, idx_d;
    logic            acc_q, acc_d;
    logic            sin_q, sin_d;
    logic            shift_en_q, shift_en_d;
    logic            reg_clr_n_q, reg_clr_n_d;
    logic            busy_q, busy_d;
    logic            rx_done_q, rx_done_d;
    logic            perr_q, perr_d;
    logic            ferr_q, ferr_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            idx_q       <= '0;
            acc_q       <= 1'b0;
            sin_q       <= 1'b1;
            shift_en_q  <= 1'b0;
            reg_clr_n_q <= 1'b0;
            busy_q      <= 1'b0;
            rx_done_q   <= 1'b0;
            perr_q      <= 1'b0;
            ferr_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            acc_q       <= acc_d;
            sin_q       <= sin_d;
            shift_en_q  <= shift_en_d;
            reg_clr_n_q <= reg_clr_n_d;
            busy_q      <= busy_d;
            rx_done_q   <= rx_done_d;
            perr_q      <= perr_d;
            ferr_q      <= ferr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + 1'b1;
        idx_d       = idx_q;
        acc_d       = acc_q;
        sin_d       = sin_q;
        shift_en_d  = 1'b0;
        reg_clr_n_d = 1'b1;
        busy_d      = busy_q;
        rx_done_d   = 1'b0;
        perr_d      = perr_q;
        ferr_d      = ferr_q;

        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (rx_fall) begin
                    state_d = StStart;
                    busy_d  = 1'b1;
                end
            end
            StStart: begin
                if (cnt_q == StartPt) begin
                    cnt_d = '0;
                    if (sample) begin
                        // Line back high at mid start bit: glitch, not a frame.
                        state_d = StIdle;
                        busy_d  = 1'b0;
                    end else begin
                        state_d     = StData;
                        reg_clr_n_d = 1'b0;
                        perr_d      = 1'b0;
                        ferr_d      = 1'b0;
                        acc_d       = PARITY_ODD;
                        idx_d       = '0;
                    end
                end
            end
            StData: begin
                // Counter restarts at mid start bit, so BitPt lands mid-bit.
                if (cnt_q == BitPt) begin
                    cnt_d      = '0;
                    sin_d      = sample;
                    shift_en_d = 1'b1;
                    acc_d      = acc_q ^ sample;
                    if (idx_q == LastIdx) begin
                        state_d = StStop;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            StStop: begin
                if (cnt_q == BitPt) begin
                    cnt_d     = '0;
                    ferr_d    = ~sample;
                    perr_d    = acc_q;
                    rx_done_d = 1'b1;
                    busy_d    = 1'b0;
                    state_d   = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    assign sin_o        = sin_q;
    assign shift_en_o   = shift_en_q;
    assign reg_clr_n_o  = reg_clr_n_q;
    assign busy_o       = busy_q;
    assign rx_done_o    = rx_done_q;
    assign parity_err_o = perr_q;
    assign frame_err_o  = ferr_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_ctrl: drives serial frames into uart_rx_ctrl wired to a 9-bit
// right-shift register, and checks completed frames from a scoreboard queue
// filled by the stimulus side.
// ---------------------------------------------------------------------------
module tb_uart_rx_ctrl;

    localparam int unsigned N    = 16;
    localparam bit          PODD = 1'b0;

    logic clk;
    logic rst_n;
    logic rx;
    logic sin, shift_en, reg_clr_n, busy, rx_done, perr, ferr;
    logic [8:0] sreg;

    int checks;
    int errors;
    int shift_cnt;
    int shift_total;
    int clr_total;
    int done_total;
    bit busy_seen;

    // {register[8:0], parity_err, frame_err}
    logic [10:0] exp_q[$];

    uart_rx_ctrl #(
        .CLKS_PER_BIT (N),
        .PARITY_ODD   (PODD)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .rx_i         (rx),
        .sin_o        (sin),
        .shift_en_o   (shift_en),
        .reg_clr_n_o  (reg_clr_n),
        .busy_o       (busy),
        .rx_done_o    (rx_done),
        .parity_err_o (perr),
        .frame_err_o  (ferr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Receive shift register: sync active-low clear, right shift with SIn at MSB.
    always @(posedge clk) begin
        if (!reg_clr_n) sreg <= '0;
        else if (shift_en) sreg <= {sin, sreg[8:1]};
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every rx_done.
    always @(negedge clk) begin
        logic [10:0] e;
        if (!rst_n) begin
            shift_cnt = 0;
        end else begin
            if (shift_en) begin
                shift_cnt++;
                shift_total++;
            end
            if (busy) busy_seen = 1'b1;
            if (!reg_clr_n) begin
                clr_total++;
                check("errs_clear_on_start", {30'd0, perr, ferr}, 32'd0);
            end
            if (rx_done) begin
                done_total++;
                if (exp_q.size() == 0) begin
                    check("unexpected_rx_done", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("frame_reg", {23'd0, sreg}, {23'd0, e[10:2]});
                    check("frame_parity_err", {31'd0, perr}, {31'd0, e[1]});
                    check("frame_frame_err", {31'd0, ferr}, {31'd0, e[0]});
                    check("frame_shift_count", shift_cnt, 9);
                    check("busy_low_at_done", {31'd0, busy}, 32'd0);
                end
                shift_cnt = 0;
            end
        end
    end

    function automatic logic [10:0] model(input logic [7:0] data, input logic pbit,
                                          input logic stop);
        logic err;
        // Even parity: data plus parity bit holds an even number of ones.
        err = (^data) ^ pbit ^ PODD;
        return {pbit, data, err, ~stop};
    endfunction

    // Drives start, 8 data bits, parity, stop; glitch_bit flips one cycle at the
    // middle of that bit slot; limit truncates the frame after that many cycles.
    task automatic drive_frame(input logic [7:0] data, input logic pbit, input logic stop,
                               input int glitch_bit, input int limit);
        logic [10:0] bits;
        int b;
        bits = {stop, pbit, data, 1'b0};
        for (int i = 0; i < 11 * N && i < limit; i++) begin
            b = i / N;
            @(negedge clk);
            rx = (b == glitch_bit && (i % N) == N / 2) ? ~bits[b] : bits[b];
        end
    endtask

    task automatic idle(input int cycles);
        @(negedge clk);
        rx = 1'b1;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] data, input logic pbit, input logic stop);
        exp_q.push_back(model(data, pbit, stop));
        drive_frame(data, pbit, stop, -1, 11 * N);
        idle(N);
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 20 * N) begin
            @(negedge clk);
            k++;
        end
        check(name, exp_q.size(), 0);
    endtask

    task automatic check_reset_values(input string name);
        check(name, {25'd0, sin, shift_en, reg_clr_n, busy, rx_done, perr, ferr},
              {25'd0, 7'b1000000});
    endtask

    initial begin
        int d0, c0, s0;
        logic [7:0] data;
        logic pbit, stop;

        checks = 0;
        errors = 0;
        shift_total = 0;
        clr_total = 0;
        done_total = 0;
        busy_seen = 1'b0;
        rx = 1'b1;
        rst_n = 1'b0;

        repeat (3) @(negedge clk);
        check_reset_values("reset_values");
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("reg_clr_n_release", {31'd0, reg_clr_n}, 32'd1);
        idle(4);

        // Case 1: clean 0xA5.
        send(8'hA5, 1'b0, 1'b1);
        drain("drain_a5");

        // Case 2: bad parity then a clean frame.
        send(8'hA5, 1'b1, 1'b1);
        drain("drain_a5_bad_parity");
        check("parity_err_held", {31'd0, perr}, 32'd1);
        send(8'h3C, 1'b0, 1'b1);
        drain("drain_3c");

        // Case 3: 5-cycle low pulse is a false start.
        d0 = done_total; c0 = clr_total; s0 = shift_total;
        busy_seen = 1'b0;
        @(negedge clk);
        rx = 1'b0;
        repeat (5) @(negedge clk);
        rx = 1'b1;
        repeat (3 * N) @(negedge clk);
        check("false_start_busy_seen", {31'd0, busy_seen}, 32'd1);
        check("false_start_busy_low", {31'd0, busy}, 32'd0);
        check("false_start_no_shift", shift_total - s0, 0);
        check("false_start_no_clear", clr_total - c0, 0);
        check("false_start_no_done", done_total - d0, 0);

        // Case 4: stop bit low, line held low, then released.
        d0 = done_total;
        exp_q.push_back(model(8'h00, 1'b0, 1'b0));
        drive_frame(8'h00, 1'b0, 1'b0, -1, 11 * N);
        repeat (40) @(negedge clk);
        rx = 1'b1;
        repeat (3 * N) @(negedge clk);
        drain("drain_break");
        check("break_single_done", done_total - d0, 1);
        check("break_frame_err_held", {31'd0, ferr}, 32'd1);
        check("break_busy_low", {31'd0, busy}, 32'd0);

        // Case 5: reset mid-DATA after four shifts, then a full 0x5A.
        s0 = shift_total;
        drive_frame(8'h5A, 1'b0, 1'b1, -1, 5 * N + 4);
        check("midframe_four_shifts", shift_total - s0, 4);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_values("midframe_reset_values");
        @(negedge clk);
        rst_n = 1'b1;
        rx = 1'b1;
        idle(2 * N);
        check("midframe_no_done_busy", {31'd0, busy}, 32'd0);
        send(8'h5A, 1'b0, 1'b1);
        drain("drain_5a");

        // Randomised frames: random data, occasional bad parity or low stop.
        for (int n = 0; n < 8; n++) begin
            data = 8'($urandom_range(0, 255));
            pbit = (^data) ^ PODD ^ ($urandom_range(0, 3) == 0);
            stop = ($urandom_range(0, 4) != 0);
            send(data, pbit, stop);
        end
        drain("drain_random");

`ifdef UART_RX_MAJORITY_EN
        // Case 6: single-cycle glitch at mid data bit 3 of 0xFF.
        exp_q.push_back(model(8'hFF, 1'b0, 1'b1));
        drive_frame(8'hFF, 1'b0, 1'b1, 4, 11 * N);
        idle(N);
        drain("drain_glitch_ff");
`endif

        check("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
